branch_resolve_unit: RTL and testbench

- Parametrised successor to the ID-stage branch comparator.
- Evaluates all MIPS conditional-branch conditions on WIDTH-bit operands, including the link variants bltzal and bgezal.
- Registers the outcome as one resolve pulse per branch and flags mispredicts against the fetch-time guess.
- Trains a DEPTH-entry table of 2-bit saturating counters that the IF stage reads combinationally for prediction.

---
 rtl/bru_pkg.sv | 28 ++
 rtl/bht_sat_table.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 121 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: MIPS branch codes and
// 2-bit saturating counter encodings.
package bru_pkg;

    // Condition codes carried on Br; 9..15 are "not a branch".
    localparam logic [3:0] BR_NONE   = 4'd0;
    localparam logic [3:0] BR_BEQ    = 4'd1;
    localparam logic [3:0] BR_BNE    = 4'd2;
    localparam logic [3:0] BR_BLEZ   = 4'd3;
    localparam logic [3:0] BR_BGTZ   = 4'd4;
    localparam logic [3:0] BR_BLTZ   = 4'd5;
    localparam logic [3:0] BR_BGEZ   = 4'd6;
    localparam logic [3:0] BR_BLTZAL = 4'd7;
    localparam logic [3:0] BR_BGEZAL = 4'd8;

    // Counter states; the MSB is the taken prediction.
    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    // True only for the eight real branch codes; X codes do not match.
    function automatic logic is_branch(input logic [3:0] br);
        return (br >= BR_BEQ) && (br <= BR_BGEZAL);
    endfunction

endpackage

// File: rtl/bht_sat_table.sv
// Table of 2-bit saturating counters: one combinational read port and one
// write port that trains the addressed counter toward the branch outcome.
module bht_sat_table
    import bru_pkg::*;
#(
    parameter  int DEPTH    = 16,
    localparam int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_cnt_o,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d;

    // Read sees the pre-edge value, so a same-index write is read-before-write.
    assign rd_cnt_o = cnt_q[rd_idx_i];

    // Saturating step of the counter being written.
    always_comb begin
        cnt_d = cnt_q[wr_idx_i];
        if (wr_taken_i) begin
            if (cnt_d != CNT_ST) cnt_d = cnt_d + 2'd1;
        end else begin
            if (cnt_d != CNT_SNT) cnt_d = cnt_d - 2'd1;
        end
    end

    // Counter array; reset returns every entry to weakly-not-taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RESET;
        end else if (we_i) begin
            cnt_q[wr_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: evaluates the MIPS branch condition, registers
// a one-cycle resolve result with mispredict/link flags, and trains the BHT
// that the IF stage reads for prediction.
//
// Handshake: a branch is taken in on a rising edge when en=1, flush=0,
// valid_in=1 and Br is a real branch code; the result appears on res_* for
// the following cycle. en=0 holds res_*, flush clears them and wins over en.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_BITS  = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [3:0]       Br,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [31:0]      pc_in,
    input  logic             pred_in,
    input  logic [31:0]      lookup_pc,
    output logic             lookup_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic             res_link
);

    logic cond;
    logic accept;
    logic is_link;
    logic d1_neg;
    logic d1_zero;
    logic [1:0] lookup_cnt;
    logic res_valid_q, res_valid_d;
    logic res_taken_q, res_taken_d;
    logic res_mis_q,   res_mis_d;
    logic res_link_q,  res_link_d;

    // Bits outside the word-aligned table index play no part in prediction.
    logic unused_bits;
    assign unused_bits = ^{pc_in[31:IDX_BITS+2], pc_in[1:0],
                           lookup_pc[31:IDX_BITS+2], lookup_pc[1:0], lookup_cnt[0]};

    assign d1_neg  = D1[WIDTH-1];
    assign d1_zero = (D1 == '0);
    assign is_link = (Br == BR_BLTZAL) || (Br == BR_BGEZAL);
    assign accept  = en && !flush && valid_in && is_branch(Br);

    // Signed branch condition for the presented code.
    always_comb begin
        cond = 1'b0;
        case (Br)
            BR_BEQ:              cond = (D1 == D2);
            BR_BNE:              cond = (D1 != D2);
            BR_BLEZ:             cond = d1_neg || d1_zero;
            BR_BGTZ:             cond = !d1_neg && !d1_zero;
            BR_BLTZ, BR_BLTZAL:  cond = d1_neg;
            BR_BGEZ, BR_BGEZAL:  cond = !d1_neg;
            default:             cond = 1'b0;
        endcase
    end

    // Next resolve result: flush clears, stall holds, advance loads or clears.
    always_comb begin
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        res_mis_d   = res_mis_q;
        res_link_d  = res_link_q;
        if (flush) begin
            res_valid_d = 1'b0;
            res_taken_d = 1'b0;
            res_mis_d   = 1'b0;
            res_link_d  = 1'b0;
        end else if (en) begin
            res_valid_d = accept;
            res_taken_d = accept && cond;
            res_mis_d   = accept && (cond != pred_in);
            res_link_d  = accept && is_link;
        end
    end

    // Resolve result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_mis_q   <= 1'b0;
            res_link_q  <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            res_mis_q   <= res_mis_d;
            res_link_q  <= res_link_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_mis_q;
    assign res_link       = res_link_q;

    bht_sat_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk_i      (clk),
        .rst_ni     (reset),
        .rd_idx_i   (lookup_pc[IDX_BITS+1:2]),
        .rd_cnt_o   (lookup_cnt),
        .we_i       (accept),
        .wr_idx_i   (pc_in[IDX_BITS+1:2]),
        .wr_taken_i (cond)
    );

    assign lookup_taken = lookup_cnt[1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a 32-bit and an 8-bit instance share all
// inputs (the 8-bit one sees the low byte of D1/D2) and are compared every
// cycle against a signed-arithmetic reference model of results and counters.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  Br = 4'd0;
    logic [31:0] D1 = '0;
    logic [31:0] D2 = '0;
    logic [31:0] pc_in = 32'h3000;
    logic        pred_in = 1'b0;
    logic [31:0] lookup_pc = 32'h3000;

    logic lt32, rv32, rt32, rm32, rl32;
    logic lt8, rv8, rt8, rm8, rl8;

    int checks = 0;
    int failures = 0;

    // Reference state: counters as 0..3 integers and packed {valid,taken,mis,link}.
    int       m_bht [2][16];
    bit [3:0] m_res [2];

    typedef struct {
        logic [3:0]  br;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        pred;
        logic [3:0]  exp32;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
        .Br(Br), .D1(D1), .D2(D2), .pc_in(pc_in), .pred_in(pred_in),
        .lookup_pc(lookup_pc), .lookup_taken(lt32), .res_valid(rv32),
        .res_taken(rt32), .res_mispredict(rm32), .res_link(rl32)
    );

    branch_resolve_unit #(.WIDTH(8), .BHT_DEPTH(16)) dut8 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
        .Br(Br), .D1(D1[7:0]), .D2(D2[7:0]), .pc_in(pc_in), .pred_in(pred_in),
        .lookup_pc(lookup_pc), .lookup_taken(lt8), .res_valid(rv8),
        .res_taken(rt8), .res_mispredict(rm8), .res_link(rl8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sx(input int k, input logic [31:0] v);
        logic [7:0] b;
        b = v[7:0];
        if (k == 0) return longint'($signed(v));
        return longint'($signed(b));
    endfunction

    function automatic bit mcond(input logic [3:0] br, input longint a, input longint b);
        case (br)
            4'd1:       return a == b;
            4'd2:       return a != b;
            4'd3:       return a <= 0;
            4'd4:       return a > 0;
            4'd5, 4'd7: return a < 0;
            4'd6, 4'd8: return a >= 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] act_tbl(input int k);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 16; i++)
            t[2*i +: 2] = (k == 0) ? dut.u_bht.cnt_q[i] : dut8.u_bht.cnt_q[i];
        return t;
    endfunction

    function automatic logic [31:0] exp_tbl(input int k);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[2*i +: 2] = 2'(m_bht[k][i]);
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_res[k] = '0;
            for (int i = 0; i < 16; i++) m_bht[k][i] = 1;
        end
    endtask

    // Called at posedge+1: checks lookup pre-edge, clocks once, checks results.
    task automatic cycle();
        bit [3:0] n_res [2];
        int       n_idx;
        int       n_cnt [2];
        bit       acc;
        bit       c;
        int       li;
        #2;
        li = int'(lookup_pc[5:2]);
        chk("lookup32", 32'(lt32), 32'(m_bht[0][li] >= 2));
        chk("lookup8",  32'(lt8),  32'(m_bht[1][li] >= 2));
        n_idx = int'(pc_in[5:2]);
        acc = en && !flush && valid_in && (Br >= 4'd1) && (Br <= 4'd8);
        for (int k = 0; k < 2; k++) begin
            c = mcond(Br, sx(k, D1), sx(k, D2));
            if (flush)   n_res[k] = 4'b0000;
            else if (en) n_res[k] = {acc, acc && c, acc && (c != pred_in),
                                     acc && (Br == 4'd7 || Br == 4'd8)};
            else         n_res[k] = m_res[k];
            n_cnt[k] = m_bht[k][n_idx];
            if (acc) n_cnt[k] = c ? ((n_cnt[k] < 3) ? n_cnt[k] + 1 : 3)
                                  : ((n_cnt[k] > 0) ? n_cnt[k] - 1 : 0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_res[k] = n_res[k];
            m_bht[k][n_idx] = n_cnt[k];
        end
        #1;
        chk("res32", 32'({rv32, rt32, rm32, rl32}), 32'(m_res[0]));
        chk("res8",  32'({rv8, rt8, rm8, rl8}),     32'(m_res[1]));
        chk("tbl32", act_tbl(0), exp_tbl(0));
        chk("tbl8",  act_tbl(1), exp_tbl(1));
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #3;
        model_reset();
        chk("rst_res32", 32'({rv32, rt32, rm32, rl32}), 32'h0);
        chk("rst_res8",  32'({rv8, rt8, rm8, rl8}),     32'h0);
        chk("rst_tbl32", act_tbl(0), 32'h5555_5555);
        chk("rst_tbl8",  act_tbl(1), 32'h5555_5555);
        valid_in = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [3:0] br, input logic [31:0] a, input logic [31:0] b,
                          input logic p, input logic [31:0] pc);
        Br = br; D1 = a; D2 = b; pred_in = p; pc_in = pc; valid_in = 1'b1;
    endtask

    initial begin
        vecs = '{
            '{4'd1, 32'd7,          32'd7, 1'b1, 4'b1100},
            '{4'd1, 32'd7,          32'd8, 1'b1, 4'b1010},
            '{4'd2, 32'd7,          32'd8, 1'b0, 4'b1110},
            '{4'd3, 32'd0,          32'd0, 1'b1, 4'b1100},
            '{4'd3, 32'hFFFF_FFFF,  32'd0, 1'b0, 4'b1110},
            '{4'd3, 32'd1,          32'd0, 1'b0, 4'b1000},
            '{4'd4, 32'd1,          32'd0, 1'b1, 4'b1100},
            '{4'd4, 32'd0,          32'd0, 1'b1, 4'b1010},
            '{4'd4, 32'h8000_0000,  32'd0, 1'b0, 4'b1000},
            '{4'd5, 32'h8000_0000,  32'd0, 1'b1, 4'b1100},
            '{4'd5, 32'h7FFF_FFFF,  32'd0, 1'b0, 4'b1000},
            '{4'd6, 32'd0,          32'd0, 1'b1, 4'b1100},
            '{4'd6, 32'hFFFF_FFFF,  32'd0, 1'b0, 4'b1000},
            '{4'd7, 32'hFFFF_FFFE,  32'd0, 1'b0, 4'b1111},
            '{4'd7, 32'd5,          32'd0, 1'b0, 4'b1001},
            '{4'd8, 32'd5,          32'd0, 1'b1, 4'b1101},
            '{4'd0, 32'd0,          32'd0, 1'b1, 4'b0000},
            '{4'd9, 32'd0,          32'd0, 1'b1, 4'b0000},
            '{4'd15, 32'd0,         32'd0, 1'b1, 4'b0000}
        };

        // Reset state and first lookup.
        do_reset();
        lookup_pc = 32'h3000;
        #1;
        chk("rst_lookup", 32'(lt32), 32'h0);
        valid_in = 1'b0;
        cycle();
        chk("idle_res", 32'({rv32, rt32, rm32, rl32}), 32'h0);

        // Taken beq predicted not-taken.
        set_br(4'd1, 32'h5, 32'h5, 1'b0, 32'h3004);
        cycle();
        chk("beq_res", 32'({rv32, rt32, rm32, rl32}), 32'b1110);
        chk("beq_cnt1", 32'(dut.u_bht.cnt_q[1]), 32'b10);

        // Same taken branch three times: 01 -> 10 -> 11 -> 11.
        lookup_pc = 32'h3008;
        set_br(4'd1, 32'h9, 32'h9, 1'b1, 32'h3008);
        cycle();
        chk("sat_cnt_a", 32'(dut.u_bht.cnt_q[2]), 32'b10);
        cycle();
        chk("sat_cnt_b", 32'(dut.u_bht.cnt_q[2]), 32'b11);
        cycle();
        chk("sat_cnt_c", 32'(dut.u_bht.cnt_q[2]), 32'b11);
        chk("sat_lookup", 32'(lt32), 32'h1);

        // bgezal on a negative operand still links; flush kills the same branch.
        set_br(4'd8, 32'h8000_0000, 32'h0, 1'b0, 32'h300C);
        cycle();
        chk("bgezal_res", 32'({rv32, rt32, rm32, rl32}), 32'b1001);
        chk("bgezal_cnt3", 32'(dut.u_bht.cnt_q[3]), 32'b00);
        flush = 1'b1;
        cycle();
        chk("flush_res", 32'({rv32, rt32, rm32, rl32}), 32'b0000);
        chk("flush_cnt3", 32'(dut.u_bht.cnt_q[3]), 32'b00);
        flush = 1'b0;

        // Stall holds the result, then an invalid code clears it without a write.
        set_br(4'd2, 32'h1, 32'h2, 1'b1, 32'h3010);
        cycle();
        en = 1'b0;
        set_br(4'd1, 32'h3, 32'h3, 1'b0, 32'h3010);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_res", 32'({rv32, rt32, rm32, rl32}), 32'b1100);
            chk("stall_cnt4", 32'(dut.u_bht.cnt_q[4]), 32'b10);
        end
        en = 1'b1;
        set_br(4'd12, 32'h3, 32'h3, 1'b0, 32'h3010);
        cycle();
        chk("br12_res", 32'({rv32, rt32, rm32, rl32}), 32'b0000);
        chk("br12_cnt4", 32'(dut.u_bht.cnt_q[4]), 32'b10);

        // 8-bit signed boundaries, then reset in the middle of a stall.
        set_br(4'd3, 32'h80, 32'h0, 1'b0, 32'h3014);
        cycle();
        chk("w8_blez", 32'({rv8, rt8, rm8, rl8}), 32'b1110);
        set_br(4'd4, 32'h00, 32'h0, 1'b1, 32'h3014);
        cycle();
        chk("w8_bgtz", 32'({rv8, rt8, rm8, rl8}), 32'b1010);
        en = 1'b0;
        cycle();
        do_reset();
        en = 1'b1;

        // Table of single-branch vectors.
        for (int i = 0; i < 19; i++) begin
            set_br(vecs[i].br, vecs[i].d1, vecs[i].d2, vecs[i].pred, 32'h3000 + 32'(i * 4));
            cycle();
            chk($sformatf("vec%0d", i), 32'({rv32, rt32, rm32, rl32}), 32'(vecs[i].exp32));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            Br = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       D1 = 32'h0;
                1:       D1 = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: D1 = $urandom;
            endcase
            D2 = ($urandom_range(0, 2) == 0) ? D1 : $urandom;
            pred_in  = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            valid_in = ($urandom_range(0, 7) != 0);
            pc_in    = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 15) << 2);
            lookup_pc = ($urandom_range(0, 3) == 0) ? pc_in
                                                    : 32'h3000 + 32'($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
